// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the cached-top stack controller.
// Holds the data width, the op and FSM encodings, and the capacity
// expression, so that the controller and its users agree on them.
package stack_ctrl_pkg;

   // Data width of one stack entry.
   localparam int WIDTH = 8;

   // Op encoding on the op port.
   typedef logic [1:0] op_t;
   localparam op_t OP_NOP  = 2'd0;
   localparam op_t OP_PUSH = 2'd1;
   localparam op_t OP_POP  = 2'd2;
   localparam op_t OP_REPL = 2'd3;

   // Controller FSM encoding, kept as plain constants so that the encoding
   // stays stable for existing consumers.
   typedef logic [1:0] state_t;
   localparam state_t ST_INIT  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_FAULT = 2'd2;

   // Capacity: the cached TOS register plus every spill-memory word.
   function automatic int cap_of(input int depth);
      return (1 << depth) + 1;
   endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller with the top entry cached in a register.
// Older entries spill into an external memory that the parent owns
// (combinational read, synchronous write). After reset or a fault clear,
// the controller zeroes that memory once, one word per cycle, and only
// then starts taking ops. Overflow and underflow are sticky: the
// controller stops in FAULT until err_clr is asserted.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetq,
   // op interface
   input  logic             op_valid,
   output logic             op_ready,
   input  op_t              op,
   input  logic [WIDTH-1:0] op_data,
   // stack view
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [DEPTH:0]   count,
   output logic             empty,
   output logic             full,
   // sticky errors
   output logic             err_ovf,
   output logic             err_unf,
   input  logic             err_clr,
   // spill memory port
   output logic [DEPTH-1:0] mem_ra,
   input  logic [WIDTH-1:0] mem_rd,
   output logic             mem_we,
   output logic [DEPTH-1:0] mem_wa,
   output logic [WIDTH-1:0] mem_wd
);

   localparam logic [DEPTH:0]   CAP        = (DEPTH+1)'(cap_of(DEPTH));
   localparam logic [DEPTH:0]   CNT_ONE    = (DEPTH+1)'(1);
   localparam logic [DEPTH:0]   CNT_TWO    = (DEPTH+1)'(2);
   localparam logic [DEPTH-1:0] SP_INIT    = '1;
   localparam logic [DEPTH-1:0] SWEEP_LAST = '1;

   state_t           state_reg,   state_next;
   logic [DEPTH-1:0] sweep_reg,   sweep_next;
   logic [DEPTH-1:0] sp_reg,      sp_next;
   logic [DEPTH:0]   count_reg,   count_next;
   logic [WIDTH-1:0] tos_reg,     tos_next;
   logic             err_ovf_reg, err_ovf_next;
   logic             err_unf_reg, err_unf_next;

   logic             in_run;
   logic             fire;
   logic             is_empty;
   logic             is_full;
   logic             spill;
   logic [DEPTH-1:0] sp_inc;
   logic [DEPTH-1:0] sp_dec;

   // Handshake and occupancy decode shared by the next-state and memory logic.
   always_comb begin
      in_run   = (state_reg == ST_RUN);
      fire     = op_valid && in_run;
      is_empty = (count_reg == '0);
      is_full  = (count_reg == CAP);
      sp_inc   = sp_reg + 1'b1;
      sp_dec   = sp_reg - 1'b1;
      // A push onto a non-empty, non-full stack moves the old top to memory.
      spill    = fire && (op == OP_PUSH) && !is_empty && !is_full;
   end

   // Next-state logic: init sweep, op execution and fault handling.
   always_comb begin
      state_next   = state_reg;
      sweep_next   = sweep_reg;
      sp_next      = sp_reg;
      count_next   = count_reg;
      tos_next     = tos_reg;
      err_ovf_next = err_ovf_reg;
      err_unf_next = err_unf_reg;

      case (state_reg)
         ST_INIT: begin
            // The counter wraps back to zero on the last word, so it is
            // already at zero for the next sweep.
            sweep_next = sweep_reg + 1'b1;
            if (sweep_reg == SWEEP_LAST) begin
               state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            if (op_valid) begin
               case (op)
                  OP_PUSH: begin
                     if (is_full) begin
                        err_ovf_next = 1'b1;
                        state_next   = ST_FAULT;
                     end else if (is_empty) begin
                        // The first entry lives only in the cached top.
                        tos_next   = op_data;
                        count_next = CNT_ONE;
                     end else begin
                        sp_next    = sp_inc;
                        tos_next   = op_data;
                        count_next = count_reg + 1'b1;
                     end
                  end
                  OP_POP: begin
                     if (is_empty) begin
                        err_unf_next = 1'b1;
                        state_next   = ST_FAULT;
                     end else if (count_reg == CNT_ONE) begin
                        // Nothing is left in memory, so sp stays put.
                        tos_next   = '0;
                        count_next = '0;
                     end else begin
                        tos_next   = mem_rd;
                        sp_next    = sp_dec;
                        count_next = count_reg - 1'b1;
                     end
                  end
                  OP_REPL: begin
                     if (is_empty) begin
                        err_unf_next = 1'b1;
                        state_next   = ST_FAULT;
                     end else begin
                        tos_next = op_data;
                     end
                  end
                  default: begin
                     // NOP leaves every register as it is.
                  end
               endcase
            end
         end

         ST_FAULT: begin
            // err_clr empties the stack and schedules a fresh memory sweep.
            if (err_clr) begin
               err_ovf_next = 1'b0;
               err_unf_next = 1'b0;
               count_next   = '0;
               tos_next     = '0;
               sp_next      = SP_INIT;
               sweep_next   = '0;
               state_next   = ST_INIT;
            end
         end

         default: begin
            // Unused encoding: go back through a full clean start.
            state_next = ST_INIT;
            sweep_next = '0;
         end
      endcase
   end

   // Memory write port: the init sweep writes zeros, and otherwise only a
   // spill writes the old top.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = sweep_reg;
      mem_wd = '0;
      if (state_reg == ST_INIT) begin
         mem_we = 1'b1;
         mem_wa = sweep_reg;
         mem_wd = '0;
      end else if (spill) begin
         mem_we = 1'b1;
         mem_wa = sp_inc;
         mem_wd = tos_reg;
      end
   end

   // State registers, with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_reg   <= ST_INIT;
         sweep_reg   <= '0;
         sp_reg      <= SP_INIT;
         count_reg   <= '0;
         tos_reg     <= '0;
         err_ovf_reg <= 1'b0;
         err_unf_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sweep_reg   <= sweep_next;
         sp_reg      <= sp_next;
         count_reg   <= count_next;
         tos_reg     <= tos_next;
         err_ovf_reg <= err_ovf_next;
         err_unf_reg <= err_unf_next;
      end
   end

   // Output drive. nos comes straight from the memory read at sp, and is
   // forced to zero when memory holds no live entry.
   always_comb begin
      op_ready = in_run;
      tos      = tos_reg;
      nos      = (count_reg >= CNT_TWO) ? mem_rd : '0;
      count    = count_reg;
      empty    = is_empty;
      full     = is_full;
      err_ovf  = err_ovf_reg;
      err_unf  = err_unf_reg;
      mem_ra   = sp_reg;
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl. It plays the parent, so it owns the spill memory
// and keeps a separate model of the stack. Before each edge it pushes the
// expected post-op view onto a scoreboard queue, and after the edge it pops
// that entry and compares it against the DUT outputs.
module tb_stack_ctrl;
   import stack_ctrl_pkg::*;

   localparam int DEPTH = 4;
   localparam int NMEM  = 1 << DEPTH;
   localparam int CAP   = NMEM + 1;

   logic             clk = 1'b0;
   logic             resetq;
   logic             op_valid;
   logic             op_ready;
   op_t              op;
   logic [WIDTH-1:0] op_data;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [DEPTH:0]   count;
   logic             empty;
   logic             full;
   logic             err_ovf;
   logic             err_unf;
   logic             err_clr;
   logic [DEPTH-1:0] mem_ra;
   logic [WIDTH-1:0] mem_rd;
   logic             mem_we;
   logic [DEPTH-1:0] mem_wa;
   logic [WIDTH-1:0] mem_wd;

   logic [WIDTH-1:0] mem [NMEM];

   typedef struct {
      int tos;
      int nos;
      int count;
      int ovf;
      int unf;
      int ready;
      int sp;
   } exp_t;

   exp_t sb_q[$];
   int   mstk[$];
   int   m_sp;
   bit   m_fault;
   bit   m_ovf;
   bit   m_unf;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   stack_ctrl #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .resetq   (resetq),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op       (op),
      .op_data  (op_data),
      .tos      (tos),
      .nos      (nos),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .err_ovf  (err_ovf),
      .err_unf  (err_unf),
      .err_clr  (err_clr),
      .mem_ra   (mem_ra),
      .mem_rd   (mem_rd),
      .mem_we   (mem_we),
      .mem_wa   (mem_wa),
      .mem_wd   (mem_wd)
   );

   // Spill memory as the parent provides it.
   assign mem_rd = mem[mem_ra];
   always @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t snap();
      exp_t e;
      int   n;
      n       = mstk.size();
      e.count = n;
      e.tos   = (n >= 1) ? mstk[n-1] : 0;
      e.nos   = (n >= 2) ? mstk[n-2] : 0;
      e.ovf   = int'(m_ovf);
      e.unf   = int'(m_unf);
      e.ready = int'(!m_fault);
      e.sp    = m_sp;
      return e;
   endfunction

   task automatic model_clear();
      mstk.delete();
      m_sp    = NMEM - 1;
      m_fault = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   // Drive one op from a negedge, check the write port before the edge, and
   // check the popped scoreboard entry after it.
   task automatic issue(input op_t o, input logic [WIDTH-1:0] d);
      int   n;
      bit   exp_we;
      int   exp_wa;
      exp_t e;
      n        = mstk.size();
      op_valid = 1'b1;
      op       = o;
      op_data  = d;
      #1;
      exp_we = !m_fault && (o == OP_PUSH) && (n >= 1) && (n < CAP);
      exp_wa = (m_sp + 1) % NMEM;
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
         chk("mem_wa", 32'(mem_wa), 32'(exp_wa));
         chk("mem_wd", 32'(mem_wd), 32'(mstk[n-1]));
      end
      if (!m_fault) begin
         case (o)
            OP_PUSH: begin
               if (n == CAP) begin
                  m_ovf = 1'b1; m_fault = 1'b1;
               end else begin
                  if (n >= 1) m_sp = exp_wa;
                  mstk.push_back(int'(d));
               end
            end
            OP_POP: begin
               if (n == 0) begin
                  m_unf = 1'b1; m_fault = 1'b1;
               end else begin
                  if (n >= 2) m_sp = (m_sp + NMEM - 1) % NMEM;
                  void'(mstk.pop_back());
               end
            end
            OP_REPL: begin
               if (n == 0) begin
                  m_unf = 1'b1; m_fault = 1'b1;
               end else begin
                  mstk[n-1] = int'(d);
               end
            end
            default: begin
            end
         endcase
      end
      sb_q.push_back(snap());
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op       = OP_NOP;
      e = sb_q.pop_front();
      $display("op=%0d data=0x%0h -> tos=0x%0h nos=0x%0h count=%0d ovf=%0b unf=%0b ready=%0b",
               o, d, tos, nos, count, err_ovf, err_unf, op_ready);
      chk("tos",      32'(tos),      32'(e.tos));
      chk("nos",      32'(nos),      32'(e.nos));
      chk("count",    32'(count),    32'(e.count));
      chk("empty",    32'(empty),    32'(e.count == 0));
      chk("full",     32'(full),     32'(e.count == CAP));
      chk("err_ovf",  32'(err_ovf),  32'(e.ovf));
      chk("err_unf",  32'(err_unf),  32'(e.unf));
      chk("op_ready", 32'(op_ready), 32'(e.ready));
      chk("mem_ra",   32'(mem_ra),   32'(e.sp));
      @(negedge clk);
   endtask

   // Walk n sweep cycles from a negedge, expecting word addresses first.. .
   task automatic sweep_check(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         chk("sweep_ready", 32'(op_ready), 32'(0));
         chk("sweep_we",    32'(mem_we),   32'(1));
         chk("sweep_wa",    32'(mem_wa),   32'(i));
         chk("sweep_wd",    32'(mem_wd),   32'(0));
         @(posedge clk);
         @(negedge clk);
      end
      $display("sweep %0d..%0d done", first, first + n - 1);
   endtask

   task automatic check_idle();
      chk("idle_ready", 32'(op_ready), 32'(1));
      chk("idle_count", 32'(count),    32'(0));
      chk("idle_empty", 32'(empty),    32'(1));
      chk("idle_tos",   32'(tos),      32'(0));
   endtask

   // Clear a fault from a negedge, then follow the full re-initialisation.
   task automatic do_clear();
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      model_clear();
      $display("err_clr -> ovf=%0b unf=%0b count=%0d ready=%0b", err_ovf, err_unf, count, op_ready);
      chk("clr_ovf",   32'(err_ovf),  32'(0));
      chk("clr_unf",   32'(err_unf),  32'(0));
      chk("clr_count", 32'(count),    32'(0));
      chk("clr_ready", 32'(op_ready), 32'(0));
      chk("clr_sp",    32'(mem_ra),   32'(NMEM - 1));
      @(negedge clk);
      sweep_check(0, NMEM);
      check_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NMEM; i++) mem[i] = 8'hA5;
      resetq   = 1'b0;
      op_valid = 1'b0;
      op       = OP_NOP;
      op_data  = '0;
      err_clr  = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);

      // Reset values while resetq is held low.
      chk("rst_ready", 32'(op_ready), 32'(0));
      chk("rst_count", 32'(count),    32'(0));
      chk("rst_tos",   32'(tos),      32'(0));
      chk("rst_ovf",   32'(err_ovf),  32'(0));
      chk("rst_unf",   32'(err_unf),  32'(0));
      chk("rst_sp",    32'(mem_ra),   32'(NMEM - 1));
      chk("rst_wa",    32'(mem_wa),   32'(0));

      // Start a sweep, then reset it partway through at word 7.
      resetq = 1'b1;
      sweep_check(0, 7);
      chk("mid_wa7", 32'(mem_wa), 32'(7));
      resetq = 1'b0;
      #1;
      chk("mid_rst_wa",    32'(mem_wa),   32'(0));
      chk("mid_rst_ready", 32'(op_ready), 32'(0));
      @(negedge clk);
      resetq = 1'b1;
      sweep_check(0, NMEM);
      check_idle();

      // Push and pop.
      issue(OP_PUSH, 8'h11);
      issue(OP_PUSH, 8'h22);
      issue(OP_PUSH, 8'h33);
      issue(OP_POP,  8'h00);
      issue(OP_POP,  8'h00);
      issue(OP_POP,  8'h00);

      // err_clr outside FAULT has no effect, and NOP changes nothing.
      err_clr = 1'b1;
      issue(OP_NOP, 8'hFF);
      err_clr = 1'b0;

      // Fill to capacity (the spill pointer wraps), then overflow.
      for (int k = 1; k <= CAP; k++) issue(OP_PUSH, 8'(k));
      issue(OP_POP,  8'h00);
      issue(OP_PUSH, 8'd17);
      issue(OP_PUSH, 8'd18);
      issue(OP_PUSH, 8'h55);
      do_clear();

      // Underflow on POP, then on REPL.
      issue(OP_POP, 8'h00);
      do_clear();
      issue(OP_REPL, 8'h44);
      do_clear();

      // Replace the top entry.
      issue(OP_PUSH, 8'h05);
      issue(OP_PUSH, 8'h06);
      issue(OP_REPL, 8'h09);
      issue(OP_POP,  8'h00);
      issue(OP_REPL, 8'h0C);
      issue(OP_POP,  8'h00);

      // A few random ops that stay within bounds.
      for (int k = 0; k < 40; k++) begin
         int   n;
         op_t  o;
         n = mstk.size();
         o = op_t'($urandom_range(1, 3));
         if (n == 0) o = OP_PUSH;
         if (n == CAP && o == OP_PUSH) o = OP_POP;
         issue(o, 8'($urandom_range(0, 255)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the stack memory address width (2**DEPTH spill entries).
REQ-002 SHALL use data width `WIDTH from common.v.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetq  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports op_valid input 1, op_ready output 1, op input 2 (0 NOP, 1 PUSH, 2 POP, 3 REPL) and op_data input `WIDTH.
REQ-006 SHALL have ports tos output `WIDTH (cached top) and nos output `WIDTH (next-on-stack).
REQ-007 SHALL have ports count output DEPTH+1, empty output 1 and full output 1.
REQ-008 SHALL have ports err_ovf output 1 and err_unf output 1 (sticky), and err_clr input 1.
REQ-009 SHALL have ports mem_ra output DEPTH, mem_rd input `WIDTH (combinational read), mem_we output 1, mem_wa output DEPTH and mem_wd output `WIDTH.

Function
REQ-010 SHALL implement three FSM states: INIT, RUN and FAULT.
REQ-011 SHALL, in INIT, write zero to mem addresses 0..2**DEPTH-1, one per cycle, hold op_ready=0, then enter RUN after 2**DEPTH cycles.
REQ-012 SHALL hold op_ready=1 only in RUN; an op executes when op_valid & op_ready at a clock edge.
REQ-013 SHALL define capacity CAP=2**DEPTH+1 (TOS plus memory); empty=(count==0) and full=(count==CAP).
REQ-014 SHALL keep internal pointer sp (DEPTH bits) addressing NOS, with sp reset value all-ones, and drive mem_ra=sp at all times.
REQ-015 SHALL, on PUSH with count==0: tos<=op_data, count<=1, no memory write.
REQ-016 SHALL, on PUSH with 1<=count<CAP: mem_we=1, mem_wa=sp+1 (mod 2**DEPTH), mem_wd=tos; then sp<=sp+1, tos<=op_data and count+1, all in the same cycle.
REQ-017 SHALL, on POP with count>=2: tos<=mem_rd, sp<=sp-1 and count-1.
REQ-018 SHALL, on POP with count==1: tos<=0, count<=0 and leave sp unchanged.
REQ-019 SHALL, on REPL with count>=1, set tos<=op_data with count and sp unchanged.
REQ-020 SHALL, on NOP, change no state.
REQ-021 SHALL, on PUSH when full: set err_ovf, leave tos, sp and count unchanged, and enter FAULT.
REQ-022 SHALL, on POP or REPL when empty: set err_unf, leave state unchanged, and enter FAULT.
REQ-023 SHALL drive nos=mem_rd when count>=2, else 0, combinationally.
REQ-024 SHALL, in FAULT, hold op_ready=0; err_clr=1 clears both error flags, sets count=0, tos=0 and sp=all-ones, and enters INIT.
REQ-025 SHALL ignore err_clr outside FAULT.
REQ-026 SHALL limit mem_we to INIT sweep writes and REQ-016 spills only.
REQ-027 SHALL give each accepted op single-cycle latency: the outputs reflect it on the next edge.

Reset
REQ-028 SHALL, with resetq=0, asynchronously set state=INIT, sweep address=0, sp=all-ones, count=0, tos=0, err_ovf=0, err_unf=0 and op_ready=0.
REQ-029 SHALL, on reset mid-sweep or mid-FAULT, restart the INIT sweep from address 0.

Structure
REQ-030 SHALL place the op encodings, FSM state encodings and CAP expression in common.v alongside `WIDTH.
REQ-031 SHALL instantiate no sub-module; the stack memory instance (stack, same DEPTH) sits in the parent and connects via the mem_* ports.

Verification
REQ-032 SHALL verify reset: release resetq at DEPTH=4 -> op_ready=0 for 16 cycles, mem_wa stepping 0..15 with mem_wd=0, then op_ready=1, count=0, empty=1.
REQ-033 SHALL verify push/pop: PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, count=3; POP -> tos=0x22, nos=0x11; POP, POP -> count=0, tos=0.
REQ-034 SHALL verify fill and overflow: 17 PUSHes of 1..17 -> full=1, tos=17; an 18th PUSH -> err_ovf=1, op_ready=0, tos=17; err_clr -> INIT sweep, then count=0.
REQ-035 SHALL verify underflow: POP on empty -> err_unf=1 and FAULT; REPL on empty after clear -> err_unf=1 again.
REQ-036 SHALL verify REPL: with stack 5,6, REPL 9 -> tos=9, nos=5, count=2, mem_we=0.
REQ-037 SHALL verify reset mid-sweep: assert resetq=0 at sweep address 7 -> the sweep restarts at 0 and takes 16 full cycles.
